// File: rtl/serial_pattern_tx_if.sv
// Bus between a pattern source/sink (master) and serial_pattern_tx (slave).
// start is a request, not a handshake: it is accepted on the edge where busy=0.
interface serial_pattern_tx_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  // busy=1 means the request is not being taken. Once it is taken, the frame
  // appears on w/w_valid, where w_valid=1 marks every cycle that carries a
  // pattern bit. done pulses for one cycle when the transfer ends.
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic             z_in;
  logic             w;
  logic             w_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] z_count;

  modport master (
    output start, pattern, repeat_cnt, z_in,
    input  w, w_valid, busy, done, z_count
  );

  modport slave (
    input  start, pattern, repeat_cnt, z_in,
    output w, w_valid, busy, done, z_count
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a captured word out MSB-first in repeated
// frames separated by idle gaps, and counts detector hits seen on z_in.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_pattern_tx_if.slave bus,
  output logic [1:0]        state_dbg
);
  localparam int IDX_W  = $clog2(WIDTH);
  localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int GAP_M1 = (GAP > 0) ? GAP - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] pattern_reg, pattern_next;
  logic [IDX_W-1:0] bit_idx, bit_idx_next;
  logic [GAP_W-1:0] gap_cnt, gap_next;
  logic [CNT_W-1:0] frames_left, frames_next;
  logic [CNT_W-1:0] z_count_q;
  logic             end_frame;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pattern_reg <= '0;
      bit_idx     <= '0;
      gap_cnt     <= '0;
      frames_left <= '0;
    end else begin
      state       <= state_next;
      pattern_reg <= pattern_next;
      bit_idx     <= bit_idx_next;
      gap_cnt     <= gap_next;
      frames_left <= frames_next;
    end
  end

  always_comb begin
    state_next   = state;
    pattern_next = pattern_reg;
    bit_idx_next = bit_idx;
    gap_next     = gap_cnt;
    frames_next  = frames_left;
    end_frame    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          pattern_next = bus.pattern;
          frames_next  = (bus.repeat_cnt == '0) ? CNT_W'(1) : bus.repeat_cnt;
          bit_idx_next = IDX_W'(WIDTH - 1);
          state_next   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bit_idx == '0) begin
          if (GAP > 0) begin
            state_next = S_GAP;
            gap_next   = GAP_W'(GAP_M1);
          end else begin
            end_frame = 1'b1;
          end
        end else begin
          bit_idx_next = bit_idx - IDX_W'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) end_frame = 1'b1;
        else               gap_next  = gap_cnt - GAP_W'(1);
      end
      default: state_next = S_IDLE;
    endcase
    // Shared by the last data bit (no gap) and the last gap cycle.
    if (end_frame) begin
      if (frames_left > CNT_W'(1)) begin
        frames_next  = frames_left - CNT_W'(1);
        bit_idx_next = IDX_W'(WIDTH - 1);
        state_next   = S_SHIFT;
      end else begin
        state_next = S_DONE;
      end
    end
  end

  // The clear on an accepted start wins; the increment is gated by busy anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_count_q <= '0;
    end else if (state == S_IDLE && bus.start) begin
      z_count_q <= '0;
    end else if (state != S_IDLE && bus.z_in && z_count_q != '1) begin
      z_count_q <= z_count_q + CNT_W'(1);
    end
  end

  assign bus.w       = (state == S_SHIFT) && pattern_reg[bit_idx];
  assign bus.w_valid = (state == S_SHIFT);
  assign bus.busy    = (state != S_IDLE);
  assign bus.done    = (state == S_DONE);
  assign bus.z_count = z_count_q;
  assign state_dbg   = state;
endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx: a GAP=2 and a GAP=0 build checked
// cycle by cycle against a frame-arithmetic reference model.
module tb_serial_pattern_tx;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int GAP_A = 2;
  localparam int GAP_B = 0;
  localparam int Z_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // sel picks which build is driven and observed: 0 -> GAP_A, 1 -> GAP_B
  logic             sel = 1'b0;
  logic             start_s = 1'b0;
  logic [WIDTH-1:0] pattern_s = '0;
  logic [CNT_W-1:0] rep_s = '0;
  logic             z_s = 1'b0;
  logic [1:0]       state_a, state_b;

  serial_pattern_tx_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus_a ();
  serial_pattern_tx_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus_b ();

  serial_pattern_tx #(.WIDTH(WIDTH), .GAP(GAP_A), .CNT_W(CNT_W)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave), .state_dbg(state_a)
  );
  serial_pattern_tx #(.WIDTH(WIDTH), .GAP(GAP_B), .CNT_W(CNT_W)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave), .state_dbg(state_b)
  );

  assign bus_a.start      = sel ? 1'b0 : start_s;
  assign bus_b.start      = sel ? start_s : 1'b0;
  assign bus_a.pattern    = pattern_s;
  assign bus_b.pattern    = pattern_s;
  assign bus_a.repeat_cnt = rep_s;
  assign bus_b.repeat_cnt = rep_s;
  assign bus_a.z_in       = sel ? 1'b0 : z_s;
  assign bus_b.z_in       = sel ? z_s : 1'b0;

  logic             obs_w, obs_valid, obs_busy, obs_done;
  logic [CNT_W-1:0] obs_z;
  assign obs_w     = sel ? bus_b.w       : bus_a.w;
  assign obs_valid = sel ? bus_b.w_valid : bus_a.w_valid;
  assign obs_busy  = sel ? bus_b.busy    : bus_a.busy;
  assign obs_done  = sel ? bus_b.done    : bus_a.done;
  assign obs_z     = sel ? bus_b.z_count : bus_a.z_count;

  // z_mode: 0 low, 1 high, 2 random. noise: 0 none, 1 start at cycle 5 and
  // in the done cycle, 2 random start/pattern/repeat churn while busy.
  task automatic run_transfer(input logic [WIDTH-1:0] pat, input logic [CNT_W-1:0] rep,
                              input int z_mode, input int noise, input string name);
    int n, frame_len, total, zc, pos;
    logic exp_w, exp_valid, exp_busy, exp_done;
    logic [CNT_W-1:0] exp_z;
    n = (rep == 0) ? 1 : int'(rep);
    frame_len = WIDTH + (sel ? GAP_B : GAP_A);
    total = n * frame_len + 1;
    zc = 0;
    @(posedge clk); #1;
    start_s = 1'b1; pattern_s = pat; rep_s = rep; z_s = 1'b0;
    @(posedge clk); #1;
    start_s = 1'b0;
    for (int k = 1; k <= total + 1; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
      end
      z_s = (z_mode == 1) ? 1'b1 : (z_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise == 1) start_s = (k == 5 || k == total);
      if (noise == 2) begin
        start_s   = 1'($urandom_range(0, 1));
        pattern_s = WIDTH'($urandom);
        rep_s     = CNT_W'($urandom);
      end
      if (k == total + 1) start_s = 1'b0;
      @(negedge clk);
      if (k < total) begin
        pos = (k - 1) % frame_len;
        exp_valid = (pos < WIDTH);
        exp_w = exp_valid ? pat[WIDTH - 1 - pos] : 1'b0;
        exp_busy = 1'b1; exp_done = 1'b0;
      end else if (k == total) begin
        exp_valid = 1'b0; exp_w = 1'b0; exp_busy = 1'b1; exp_done = 1'b1;
      end else begin
        exp_valid = 1'b0; exp_w = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
      end
      exp_z = (zc > Z_MAX) ? CNT_W'(Z_MAX) : CNT_W'(zc);
      checks += 5;
      if (obs_w !== exp_w) begin
        errors++; $display("FAIL %s w cycle %0d: got %b want %b", name, k, obs_w, exp_w);
      end
      if (obs_valid !== exp_valid) begin
        errors++; $display("FAIL %s w_valid cycle %0d: got %b want %b", name, k, obs_valid, exp_valid);
      end
      if (obs_busy !== exp_busy) begin
        errors++; $display("FAIL %s busy cycle %0d: got %b want %b", name, k, obs_busy, exp_busy);
      end
      if (obs_done !== exp_done) begin
        errors++; $display("FAIL %s done cycle %0d: got %b want %b", name, k, obs_done, exp_done);
      end
      if (obs_z !== exp_z) begin
        errors++; $display("FAIL %s z_count cycle %0d: got %0d want %0d", name, k, obs_z, exp_z);
      end
      if (k <= total && z_s) zc++;
    end
    z_s = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 10;
    if (bus_a.w !== 1'b0 || bus_b.w !== 1'b0) begin
      errors += 2; $display("FAIL reset w: got %b/%b want 0/0", bus_a.w, bus_b.w);
    end
    if (bus_a.w_valid !== 1'b0 || bus_b.w_valid !== 1'b0) begin
      errors += 2; $display("FAIL reset w_valid: got %b/%b want 0/0", bus_a.w_valid, bus_b.w_valid);
    end
    if (bus_a.busy !== 1'b0 || bus_b.busy !== 1'b0) begin
      errors += 2; $display("FAIL reset busy: got %b/%b want 0/0", bus_a.busy, bus_b.busy);
    end
    if (bus_a.done !== 1'b0 || bus_b.done !== 1'b0) begin
      errors += 2; $display("FAIL reset done: got %b/%b want 0/0", bus_a.done, bus_b.done);
    end
    if (bus_a.z_count !== '0 || bus_b.z_count !== '0) begin
      errors += 2; $display("FAIL reset z_count: got %0d/%0d want 0/0", bus_a.z_count, bus_b.z_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_frame();
    sel = 1'b0;
    run_transfer(8'hB4, 4'd1, 0, 0, "single_b4");
  endtask

  task automatic test_repeat();
    sel = 1'b0;
    run_transfer(8'hFF, 4'd3, 0, 1, "repeat3_ff");
    run_transfer(8'h5A, 4'd0, 2, 0, "repeat0");
    run_transfer(8'h5A, 4'd1, 2, 0, "repeat1");
  endtask

  task automatic test_gap_zero();
    sel = 1'b1;
    run_transfer(8'h81, 4'd2, 0, 0, "gap0_81");
    run_transfer(8'hC3, 4'd3, 2, 1, "gap0_c3");
    sel = 1'b0;
  endtask

  task automatic test_z_count();
    sel = 1'b0;
    run_transfer(8'h3C, 4'd1, 1, 0, "z_one_frame");
    checks++;
    if (obs_z !== CNT_W'(11)) begin
      errors++; $display("FAIL z_one_frame final: got %0d want 11", obs_z);
    end
    run_transfer(8'h3C, 4'd2, 1, 0, "z_saturate");
    checks++;
    if (obs_z !== CNT_W'(Z_MAX)) begin
      errors++; $display("FAIL z_saturate final: got %0d want %0d", obs_z, Z_MAX);
    end
    run_transfer(8'hA5, 4'd1, 0, 0, "z_clear");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      sel = 1'($urandom_range(0, 1));
      run_transfer(WIDTH'($urandom), CNT_W'($urandom_range(0, 4)), 2, 2, "random");
    end
    sel = 1'b0;
  endtask

  task automatic test_abort();
    sel = 1'b0;
    @(posedge clk); #1;
    start_s = 1'b1; pattern_s = 8'hFF; rep_s = 4'd2; z_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    checks += 3;
    if (obs_busy !== 1'b1 || obs_w !== 1'b1) begin
      errors++; $display("FAIL abort pre busy/w: got %b/%b want 1/1", obs_busy, obs_w);
    end
    if (obs_valid !== 1'b1) begin
      errors++; $display("FAIL abort pre w_valid: got %b want 1", obs_valid);
    end
    if (obs_z !== CNT_W'(3)) begin
      errors++; $display("FAIL abort pre z_count: got %0d want 3", obs_z);
    end
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (obs_w !== 1'b0) begin
      errors++; $display("FAIL abort w: got %b want 0", obs_w);
    end
    if (obs_valid !== 1'b0) begin
      errors++; $display("FAIL abort w_valid: got %b want 0", obs_valid);
    end
    if (obs_busy !== 1'b0) begin
      errors++; $display("FAIL abort busy: got %b want 0", obs_busy);
    end
    if (obs_done !== 1'b0) begin
      errors++; $display("FAIL abort done: got %b want 0", obs_done);
    end
    if (obs_z !== '0) begin
      errors++; $display("FAIL abort z_count: got %0d want 0", obs_z);
    end
    z_s = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks += 2;
    if (obs_done !== 1'b0) begin
      errors++; $display("FAIL abort post done: got %b want 0", obs_done);
    end
    if (obs_busy !== 1'b0) begin
      errors++; $display("FAIL abort post busy: got %b want 0", obs_busy);
    end
    run_transfer(8'h0F, 4'd1, 0, 0, "after_abort");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_repeat();
    test_gap_zero();
    test_z_count();
    test_random();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
